// File: rtl/addmul_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 3-bit add/multiply unit.
// Optional completed-operation counter (op_count) is built when ADDMUL_ARB_STATS_EN is defined.
module addmul_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_op,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_op,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [5:0] res_data,
  output logic       res_id
`ifdef ADDMUL_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] op_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic       last_grant_reg;
  logic       op_reg;
  logic [2:0] a_reg, b_reg;
  logic       id_reg;
  logic [5:0] res_data_reg;
  logic       res_id_reg;

  logic       grant_en;
  logic       grant_id;
  logic [1:0] ready_vec;
  logic [3:0] sum;
  logic [5:0] prod;
  logic [5:0] result_next;

  // Grant decision; ready is also gated by rst so nothing is offered during reset.
  always_comb begin
    state_next = state_reg;
    grant_en   = 1'b0;
    grant_id   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rst && (req0_valid || req1_valid)) begin
          grant_en   = 1'b1;
          grant_id   = (req0_valid && req1_valid) ? ~last_grant_reg : req1_valid;
          state_next = EXEC;
        end
      end
      EXEC:    state_next = RESULT;
      RESULT:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = grant_en && (grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  assign sum         = {1'b0, a_reg} + {1'b0, b_reg};
  assign prod        = {3'b000, a_reg} * {3'b000, b_reg};
  assign result_next = op_reg ? {2'b00, sum} : prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      op_reg         <= 1'b0;
      a_reg          <= 3'd0;
      b_reg          <= 3'd0;
      id_reg         <= 1'b0;
      res_data_reg   <= 6'd0;
      res_id_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_en) begin
        op_reg         <= grant_id ? req1_op : req0_op;
        a_reg          <= grant_id ? req1_a  : req0_a;
        b_reg          <= grant_id ? req1_b  : req0_b;
        id_reg         <= grant_id;
        last_grant_reg <= grant_id;
      end
      // Result registers only change in EXEC, so they hold through RESULT and IDLE.
      if (state_reg == EXEC) begin
        res_data_reg <= result_next;
        res_id_reg   <= id_reg;
      end
    end
  end

  assign res_valid = (state_reg == RESULT);
  assign res_data  = res_data_reg;
  assign res_id    = res_id_reg;

`ifdef ADDMUL_ARB_STATS_EN
  logic [CNT_W-1:0] op_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_reg <= '0;
    end else if (state_reg == RESULT && res_ready) begin
      op_count_reg <= op_count_reg + 1'b1;
    end
  end

  assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_addmul_arbiter.sv
// Directed bench for addmul_arbiter: vector table of single operations plus
// hand-written backpressure, round-robin, mid-operation reset and counter sequences.
module tb_addmul_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_op;
  logic [2:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_op;
  logic [2:0] req1_a, req1_b;
  logic       res_valid, res_ready, res_id;
  logic [5:0] res_data;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

`ifdef ADDMUL_ARB_STATS_EN
  logic [1:0] op_count;
  addmul_arbiter #(.CNT_W(2)) dut (
`else
  addmul_arbiter dut (
`endif
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id)
`ifdef ADDMUL_ARB_STATS_EN
    , .op_count(op_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       id;
    bit       op;
    bit [2:0] a;
    bit [2:0] b;
    bit [5:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit id, input bit op, input bit [2:0] a, input bit [2:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  // Called at a falling edge with the FSM in IDLE; returns at a falling edge in IDLE.
  task automatic do_op(input vec_t v);
    set_req(v.id, v.op, v.a, v.b);
    res_ready = 1'b1;
    #1;
    chk("grant_ready0", req0_ready, !v.id);
    chk("grant_ready1", req1_ready, v.id);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("exec_res_valid", res_valid, 0);
    chk("exec_no_ready", req0_ready | req1_ready, 0);
    @(negedge clk);
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, v.exp_data);
    chk("res_id", res_id, v.id);
    @(negedge clk);
    hs_count++;
    chk("idle_res_valid", res_valid, 0);
    $display("op id=%0d op=%0d a=%0d b=%0d data=%0d", v.id, v.op, v.a, v.b, res_data);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    hs_count = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bit_grants[3];
    int g;
    int last_cyc;
    int exp_rr[3];
    vec_t v;

    vecs[0] = '{id: 1'b0, op: 1'b1, a: 3'd5, b: 3'd6, exp_data: 6'd11};
    vecs[1] = '{id: 1'b1, op: 1'b0, a: 3'd7, b: 3'd7, exp_data: 6'd49};
    vecs[2] = '{id: 1'b1, op: 1'b0, a: 3'd0, b: 3'd5, exp_data: 6'd0};
    vecs[3] = '{id: 1'b0, op: 1'b1, a: 3'd7, b: 3'd7, exp_data: 6'd14};
    vecs[4] = '{id: 1'b0, op: 1'b0, a: 3'd3, b: 3'd4, exp_data: 6'd12};
    vecs[5] = '{id: 1'b1, op: 1'b1, a: 3'd0, b: 3'd0, exp_data: 6'd0};
    vecs[6] = '{id: 1'b1, op: 1'b0, a: 3'd6, b: 3'd5, exp_data: 6'd30};
    exp_rr = '{0, 1, 0};

    // Reset with both requesters valid: no ready may appear.
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b0; req0_a = 3'd1; req0_b = 3'd1;
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = 3'd1; req1_b = 3'd1;
    #3;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_ready", req0_ready | req1_ready, 0);
`ifdef ADDMUL_ARB_STATS_EN
    chk("rst_op_count", op_count, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;

    foreach (vecs[i]) do_op(vecs[i]);

    // Backpressure: result must hold while res_ready is low, and nobody is granted.
    set_req(1'b1, 1'b1, 3'd3, 3'd4);
    res_ready = 1'b0;
    #1;
    chk("bp_grant1", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    set_req(1'b0, 1'b0, 3'd2, 3'd3);
    for (int k = 0; k < 5; k++) begin
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, 7);
      chk("bp_res_id", res_id, 1);
      chk("bp_no_ready", req0_ready | req1_ready, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    hs_count++;
    chk("bp_idle_res_valid", res_valid, 0);
    chk("bp_data_held", res_data, 7);
    chk("bp_idle_ready0", req0_ready, 1);
    req0_valid = 1'b0;
    $display("backpressure sequence data=%0d", res_data);

    // Round-robin with both requesters valid continuously.
    pulse_reset();
    set_req(1'b0, 1'b1, 3'd1, 3'd1);
    set_req(1'b1, 1'b0, 3'd2, 3'd2);
    res_ready = 1'b1;
    g = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 20 && g < 3; cyc++) begin
      #1;
      if (req0_ready && req1_ready) begin
        chk("rr_one_ready", 2, 1);
      end else if (req0_ready || req1_ready) begin
        bit_grants[g] = req1_ready ? 1 : 0;
        chk("rr_grant_id", bit_grants[g], exp_rr[g]);
        if (g > 0) chk("rr_spacing", cyc - last_cyc, 3);
        $display("rr grant %0d to req%0d at cycle %0d", g, bit_grants[g], cyc);
        last_cyc = cyc;
        g++;
      end
      if (g < 3) @(negedge clk);
    end
    chk("rr_grant_count", g, 3);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    hs_count += 3;
    chk("rr_idle", res_valid, 0);

    // Reset during EXEC of a req0 op: no result, and req0 wins the next contention.
    set_req(1'b0, 1'b1, 3'd1, 3'd2);
    #1;
    chk("rx_grant0", req0_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    hs_count = 0;
    set_req(1'b0, 1'b1, 3'd1, 3'd2);
    set_req(1'b1, 1'b1, 3'd1, 3'd2);
    #1;
    chk("rx_res_valid", res_valid, 0);
    chk("rx_res_data", res_data, 0);
    chk("rx_ready", req0_ready | req1_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rx_no_result", res_valid, 0);
    end
    set_req(1'b0, 1'b0, 3'd1, 3'd1);
    set_req(1'b1, 1'b0, 3'd1, 3'd1);
    #1;
    chk("rx_contention_r0", req0_ready, 1);
    chk("rx_contention_r1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    $display("reset-in-exec sequence done");

    // Five more handshakes; with a 2-bit counter the total wraps to 1.
    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      do_op(v);
    end
`ifdef ADDMUL_ARB_STATS_EN
    chk("op_count_wrap", op_count, hs_count % 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
